// File: rtl/cpu_pkg.sv
// Shared core constants: datapath widths and control-byte bit positions.
// The control byte layout is {RegWrite, MemRead, MemWrite, MemToReg, AluSrc, Branch, Jump, AluPcSrc}.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int ALUOP_W = 4;
  localparam int CNT_W   = 32;
  localparam int CTRL_W  = 8;

  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_ALUSRC   = 3;
  localparam int CTRL_BRANCH   = 2;
  localparam int CTRL_JUMP     = 1;
  localparam int CTRL_ALUPCSRC = 0;

  localparam logic [CTRL_W-1:0] BUBBLE_CTRL = 8'h00;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection between the ID instruction and a load sitting in EX.
// A taken branch flush squashes the dependent instruction, so it suppresses the stall.
module hazard_detect
  import cpu_pkg::*;
(
  input  logic              ex_valid_i,
  input  logic [CTRL_W-1:0] ex_ctrl_i,
  input  logic [4:0]        ex_rd_i,
  input  logic              id_valid_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [4:0]        id_rs1_i,
  input  logic [4:0]        id_rs2_i,
  input  logic              flush_i,
  output logic              hz_o,
  output logic              stall_o
);

  logic ex_is_load;
  logic rs1_hit;
  logic rs2_hit;

  // x0 is never written, so a load targeting it cannot create a dependency.
  assign ex_is_load = ex_valid_i & ex_ctrl_i[CTRL_MEMREAD] & ex_ctrl_i[CTRL_REGWRITE]
                    & (ex_rd_i != 5'd0);
  assign rs1_hit    = id_use_rs1_i & (id_rs1_i == ex_rd_i);
  assign rs2_hit    = id_use_rs2_i & (id_rs2_i == ex_rd_i);

  assign hz_o    = ex_is_load & id_valid_i & (rs1_hit | rs2_hit);
  assign stall_o = hz_o & ~flush_i;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush, global hold
// and a saturating count of load-use stall cycles.
module id_ex_stage #(
  parameter int XLEN    = cpu_pkg::XLEN,
  parameter int ALUOP_W = cpu_pkg::ALUOP_W,
  parameter int CNT_W   = cpu_pkg::CNT_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       hold,
  input  logic                       flush,
  input  logic                       idValid,
  input  logic [XLEN-1:0]            idPc,
  input  logic [4:0]                 idRs1Addr,
  input  logic [4:0]                 idRs2Addr,
  input  logic                       idUseRs1,
  input  logic                       idUseRs2,
  input  logic [4:0]                 idRdAddr,
  input  logic [XLEN-1:0]            idRs1Data,
  input  logic [XLEN-1:0]            idRs2Data,
  input  logic [XLEN-1:0]            idImm,
  input  logic [cpu_pkg::CTRL_W-1:0] idCtrl,
  input  logic [ALUOP_W-1:0]         idAluOp,
  output logic                       exValid,
  output logic [XLEN-1:0]            exPc,
  output logic [XLEN-1:0]            exRs1Data,
  output logic [XLEN-1:0]            exRs2Data,
  output logic [XLEN-1:0]            exImm,
  output logic [4:0]                 exRs1Addr,
  output logic [4:0]                 exRs2Addr,
  output logic [4:0]                 exRdAddr,
  output logic [cpu_pkg::CTRL_W-1:0] exCtrl,
  output logic [ALUOP_W-1:0]         exAluOp,
  output logic                       stall,
  output logic [CNT_W-1:0]           stallCount
);

  import cpu_pkg::*;

  logic               valid_q,  valid_d;
  logic [XLEN-1:0]    pc_q,     pc_d;
  logic [XLEN-1:0]    rs1d_q,   rs1d_d;
  logic [XLEN-1:0]    rs2d_q,   rs2d_d;
  logic [XLEN-1:0]    imm_q,    imm_d;
  logic [4:0]         rs1a_q,   rs1a_d;
  logic [4:0]         rs2a_q,   rs2a_d;
  logic [4:0]         rd_q,     rd_d;
  logic [CTRL_W-1:0]  ctrl_q,   ctrl_d;
  logic [ALUOP_W-1:0] aluop_q,  aluop_d;
  logic [CNT_W-1:0]   cnt_q,    cnt_d;
  logic               hz;

  hazard_detect u_hazard_detect (
    .ex_valid_i   (valid_q),
    .ex_ctrl_i    (ctrl_q),
    .ex_rd_i      (rd_q),
    .id_valid_i   (idValid),
    .id_use_rs1_i (idUseRs1),
    .id_use_rs2_i (idUseRs2),
    .id_rs1_i     (idRs1Addr),
    .id_rs2_i     (idRs2Addr),
    .flush_i      (flush),
    .hz_o         (hz),
    .stall_o      (stall)
  );

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    rs1d_d  = rs1d_q;
    rs2d_d  = rs2d_q;
    imm_d   = imm_q;
    rs1a_d  = rs1a_q;
    rs2a_d  = rs2a_q;
    rd_d    = rd_q;
    ctrl_d  = ctrl_q;
    aluop_d = aluop_q;
    cnt_d   = cnt_q;

    // hold freezes everything; flush wins over the hazard so a squashed stall is not counted.
    if (!hold) begin
      if (flush || hz) begin
        valid_d = 1'b0;
        pc_d    = '0;
        rs1d_d  = '0;
        rs2d_d  = '0;
        imm_d   = '0;
        rs1a_d  = '0;
        rs2a_d  = '0;
        rd_d    = '0;
        ctrl_d  = BUBBLE_CTRL;
        aluop_d = '0;
      end else begin
        valid_d = idValid;
        pc_d    = idPc;
        rs1d_d  = idRs1Data;
        rs2d_d  = idRs2Data;
        imm_d   = idImm;
        rs1a_d  = idRs1Addr;
        rs2a_d  = idRs2Addr;
        rd_d    = idRdAddr;
        ctrl_d  = idValid ? idCtrl : BUBBLE_CTRL;
        aluop_d = idAluOp;
      end

      if (hz && !flush && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1d_q  <= '0;
      rs2d_q  <= '0;
      imm_q   <= '0;
      rs1a_q  <= '0;
      rs2a_q  <= '0;
      rd_q    <= '0;
      ctrl_q  <= BUBBLE_CTRL;
      aluop_q <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      rs1d_q  <= rs1d_d;
      rs2d_q  <= rs2d_d;
      imm_q   <= imm_d;
      rs1a_q  <= rs1a_d;
      rs2a_q  <= rs2a_d;
      rd_q    <= rd_d;
      ctrl_q  <= ctrl_d;
      aluop_q <= aluop_d;
      cnt_q   <= cnt_d;
    end
  end

  assign exValid    = valid_q;
  assign exPc       = pc_q;
  assign exRs1Data  = rs1d_q;
  assign exRs2Data  = rs2d_q;
  assign exImm      = imm_q;
  assign exRs1Addr  = rs1a_q;
  assign exRs2Addr  = rs2a_q;
  assign exRdAddr   = rd_q;
  assign exCtrl     = ctrl_q;
  assign exAluOp    = aluop_q;
  assign stallCount = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed vector bench for id_ex_stage; a second instance with a 4-bit counter
// shares the stimulus so saturation can be reached quickly.
module tb_id_ex_stage;

  typedef struct {
    logic        hold, flush, valid;
    logic [31:0] pc;
    logic [4:0]  rs1a, rs2a;
    logic        u1, u2;
    logic [4:0]  rd;
    logic [31:0] rs1d, rs2d, imm;
    logic [7:0]  ctrl;
    logic [3:0]  alu;
    logic        e_stall, e_valid;
    logic [31:0] e_pc;
    logic [7:0]  e_ctrl;
    logic [4:0]  e_rd;
    logic [31:0] e_rs1d, e_rs2d, e_imm;
    logic [3:0]  e_alu;
    logic [31:0] e_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        hold, flush, idValid, idUseRs1, idUseRs2;
  logic [31:0] idPc, idRs1Data, idRs2Data, idImm;
  logic [4:0]  idRs1Addr, idRs2Addr, idRdAddr;
  logic [7:0]  idCtrl;
  logic [3:0]  idAluOp;

  logic        exValid, stall;
  logic [31:0] exPc, exRs1Data, exRs2Data, exImm, stallCount;
  logic [4:0]  exRs1Addr, exRs2Addr, exRdAddr;
  logic [7:0]  exCtrl;
  logic [3:0]  exAluOp;

  logic        exValid4, stall4;
  logic [31:0] exPc4, exRs1Data4, exRs2Data4, exImm4;
  logic [3:0]  stallCount4;
  logic [4:0]  exRs1Addr4, exRs2Addr4, exRdAddr4;
  logic [7:0]  exCtrl4;
  logic [3:0]  exAluOp4;

  int total = 0;
  int bad   = 0;
  vec_t vq[$];

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .idValid(idValid),
    .idPc(idPc), .idRs1Addr(idRs1Addr), .idRs2Addr(idRs2Addr),
    .idUseRs1(idUseRs1), .idUseRs2(idUseRs2), .idRdAddr(idRdAddr),
    .idRs1Data(idRs1Data), .idRs2Data(idRs2Data), .idImm(idImm),
    .idCtrl(idCtrl), .idAluOp(idAluOp),
    .exValid(exValid), .exPc(exPc), .exRs1Data(exRs1Data), .exRs2Data(exRs2Data),
    .exImm(exImm), .exRs1Addr(exRs1Addr), .exRs2Addr(exRs2Addr), .exRdAddr(exRdAddr),
    .exCtrl(exCtrl), .exAluOp(exAluOp), .stall(stall), .stallCount(stallCount)
  );

  id_ex_stage #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush), .idValid(idValid),
    .idPc(idPc), .idRs1Addr(idRs1Addr), .idRs2Addr(idRs2Addr),
    .idUseRs1(idUseRs1), .idUseRs2(idUseRs2), .idRdAddr(idRdAddr),
    .idRs1Data(idRs1Data), .idRs2Data(idRs2Data), .idImm(idImm),
    .idCtrl(idCtrl), .idAluOp(idAluOp),
    .exValid(exValid4), .exPc(exPc4), .exRs1Data(exRs1Data4), .exRs2Data(exRs2Data4),
    .exImm(exImm4), .exRs1Addr(exRs1Addr4), .exRs2Addr(exRs2Addr4), .exRdAddr(exRdAddr4),
    .exCtrl(exCtrl4), .exAluOp(exAluOp4), .stall(stall4), .stallCount(stallCount4)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic addv(input logic h, input logic f, input logic v, input logic [31:0] pc,
                      input logic [4:0] r1, input logic [4:0] r2, input logic u1,
                      input logic u2, input logic [4:0] rd, input logic [31:0] d1,
                      input logic [31:0] d2, input logic [31:0] im, input logic [7:0] c,
                      input logic [3:0] a, input logic es, input logic ev,
                      input logic [31:0] epc, input logic [7:0] ec, input logic [4:0] erd,
                      input logic [31:0] ed1, input logic [31:0] ed2, input logic [31:0] eim,
                      input logic [3:0] ea, input logic [31:0] ecnt);
    vec_t t;
    t.hold = h; t.flush = f; t.valid = v; t.pc = pc; t.rs1a = r1; t.rs2a = r2;
    t.u1 = u1; t.u2 = u2; t.rd = rd; t.rs1d = d1; t.rs2d = d2; t.imm = im;
    t.ctrl = c; t.alu = a; t.e_stall = es; t.e_valid = ev; t.e_pc = epc;
    t.e_ctrl = ec; t.e_rd = erd; t.e_rs1d = ed1; t.e_rs2d = ed2; t.e_imm = eim;
    t.e_alu = ea; t.e_cnt = ecnt;
    vq.push_back(t);
  endtask

  task automatic drive(input vec_t t);
    hold = t.hold; flush = t.flush; idValid = t.valid; idPc = t.pc;
    idRs1Addr = t.rs1a; idRs2Addr = t.rs2a; idUseRs1 = t.u1; idUseRs2 = t.u2;
    idRdAddr = t.rd; idRs1Data = t.rs1d; idRs2Data = t.rs2d; idImm = t.imm;
    idCtrl = t.ctrl; idAluOp = t.alu;
  endtask

  task automatic drive_simple(input logic [31:0] pc, input logic [4:0] r1,
                              input logic [4:0] rd, input logic [7:0] c);
    hold = 0; flush = 0; idValid = 1; idPc = pc; idRs1Addr = r1; idRs2Addr = 5'd0;
    idUseRs1 = 1; idUseRs2 = 0; idRdAddr = rd; idRs1Data = pc + 32'h1000;
    idRs2Data = 32'h0; idImm = 32'h4; idCtrl = c; idAluOp = 4'h0;
  endtask

  task automatic chk_reset_zero(input string tag);
    chk({tag, " exValid"}, exValid, 0);      chk({tag, " exCtrl"}, exCtrl, 0);
    chk({tag, " stallCount"}, stallCount, 0); chk({tag, " stall"}, stall, 0);
    chk({tag, " exPc"}, exPc, 0);            chk({tag, " exRs1Data"}, exRs1Data, 0);
    chk({tag, " exRs2Data"}, exRs2Data, 0);  chk({tag, " exImm"}, exImm, 0);
    chk({tag, " exRs1Addr"}, exRs1Addr, 0);  chk({tag, " exRs2Addr"}, exRs2Addr, 0);
    chk({tag, " exRdAddr"}, exRdAddr, 0);    chk({tag, " exAluOp"}, exAluOp, 0);
    chk({tag, " c4 stallCount"}, stallCount4, 0);
    chk({tag, " c4 exValid"}, exValid4, 0);  chk({tag, " c4 stall"}, stall4, 0);
    chk({tag, " c4 data"}, {exPc4 | exRs1Data4 | exRs2Data4 | exImm4}, 0);
    chk({tag, " c4 addr"}, {exRs1Addr4 | exRs2Addr4 | exRdAddr4}, 0);
    chk({tag, " c4 ctrl"}, {exCtrl4, exAluOp4}, 0);
  endtask

  initial begin
    // hold flush valid pc rs1a rs2a u1 u2 rd rs1d rs2d imm ctrl alu | stall valid pc ctrl rd rs1d rs2d imm alu cnt
    addv(0,0,1,'h100, 1, 2,1,1, 3,'h5,   'h7, 'h0, 'h80,'h0, 0,1,'h100,'h80, 3,'h5,   'h7, 'h0,0,0);
    addv(0,0,1,'h104, 3, 0,1,0, 5,'h1000,'h0, 'h4, 'hD8,'h0, 0,1,'h104,'hD8, 5,'h1000,'h0, 'h4,0,0);
    addv(0,0,1,'h108, 1, 5,1,1, 6,'h11,  'h22,'h0, 'h80,'h1, 1,0,'h0,  'h00, 0,'h0,   'h0, 'h0,0,1);
    addv(0,0,1,'h108, 1, 5,1,1, 6,'h11,  'h22,'h0, 'h80,'h1, 0,1,'h108,'h80, 6,'h11,  'h22,'h0,1,1);
    addv(0,0,1,'h10c, 1, 0,1,0, 0,'h200, 'h0, 'h8, 'hD8,'h0, 0,1,'h10c,'hD8, 0,'h200, 'h0, 'h8,0,1);
    addv(0,0,1,'h110, 0, 0,1,1, 7,'h0,   'h0, 'h0, 'h80,'h2, 0,1,'h110,'h80, 7,'h0,   'h0, 'h0,2,1);
    addv(0,0,1,'h114, 2, 0,1,0, 9,'h300, 'h0, 'hc, 'hD8,'h0, 0,1,'h114,'hD8, 9,'h300, 'h0, 'hc,0,1);
    addv(0,1,1,'h118, 9, 0,1,0,10,'h77,  'h0, 'h0, 'h80,'h3, 0,0,'h0,  'h00, 0,'h0,   'h0, 'h0,0,1);
    addv(0,0,0,'h11c, 1, 2,1,1, 4,'h44,  'h45,'h10,'h80,'h5, 0,0,'h11c,'h00, 4,'h44,  'h45,'h10,5,1);
    addv(0,0,1,'h120, 1, 0,1,0,12,'h400, 'h0, 'h14,'hD8,'h0, 0,1,'h120,'hD8,12,'h400, 'h0, 'h14,0,1);
    addv(1,0,1,'h124, 1,12,0,1,13,'h66,  'h67,'h0, 'h80,'h4, 1,1,'h120,'hD8,12,'h400, 'h0, 'h14,0,1);
    addv(1,0,1,'h128,12, 3,1,0,14,'h55,  'h56,'h0, 'h80,'h6, 1,1,'h120,'hD8,12,'h400, 'h0, 'h14,0,1);
    addv(1,0,1,'h12c, 1, 2,1,1,15,'h1,   'h2, 'h0, 'h80,'h7, 0,1,'h120,'hD8,12,'h400, 'h0, 'h14,0,1);
    addv(0,0,1,'h124, 1,12,0,1,13,'h66,  'h67,'h0, 'h80,'h4, 1,0,'h0,  'h00, 0,'h0,   'h0, 'h0,0,2);
    addv(0,0,1,'h124, 1,12,0,1,13,'h66,  'h67,'h0, 'h80,'h4, 0,1,'h124,'h80,13,'h66,  'h67,'h0,4,2);
    addv(1,1,1,'h130, 1, 2,1,1,16,'h9,   'h9, 'h0, 'h80,'h1, 0,1,'h124,'h80,13,'h66,  'h67,'h0,4,2);
    addv(0,1,1,'h130, 1, 2,1,1,16,'h9,   'h9, 'h0, 'h80,'h1, 0,0,'h0,  'h00, 0,'h0,   'h0, 'h0,0,2);
    addv(0,0,1,'h134, 1, 0,1,0,20,'h500, 'h0, 'h0, 'hD8,'h0, 0,1,'h134,'hD8,20,'h500, 'h0, 'h0,0,2);
    addv(0,0,0,'h138,20, 0,1,0,21,'h9,   'h8, 'h0, 'h80,'h2, 0,0,'h138,'h00,21,'h9,   'h8, 'h0,2,2);

    drive(vq[0]);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk_reset_zero("por");
    @(negedge clk) rst_n = 1'b1;

    foreach (vq[i]) begin
      @(negedge clk);
      drive(vq[i]);
      #1 chk($sformatf("v%0d stall", i), stall, vq[i].e_stall);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d exValid", i), exValid, vq[i].e_valid);
      chk($sformatf("v%0d exPc", i), exPc, vq[i].e_pc);
      chk($sformatf("v%0d exCtrl", i), exCtrl, vq[i].e_ctrl);
      chk($sformatf("v%0d exRdAddr", i), exRdAddr, vq[i].e_rd);
      chk($sformatf("v%0d exRs1Data", i), exRs1Data, vq[i].e_rs1d);
      chk($sformatf("v%0d exRs2Data", i), exRs2Data, vq[i].e_rs2d);
      chk($sformatf("v%0d exImm", i), exImm, vq[i].e_imm);
      chk($sformatf("v%0d exAluOp", i), exAluOp, vq[i].e_alu);
      chk($sformatf("v%0d stallCount", i), stallCount, vq[i].e_cnt);
    end

    // Asynchronous reset in the middle of a cycle with a live load-use hazard.
    @(negedge clk) drive_simple(32'h200, 5'd1, 5'd5, 8'hD8);
    @(negedge clk) drive_simple(32'h204, 5'd5, 5'd6, 8'h80);
    #1 chk("pre-reset stall", stall, 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_zero("midrun");
    @(negedge clk) rst_n = 1'b1;

    // Twenty load/dependent pairs: the 4-bit counter must pin at 15.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk) drive_simple(32'h300 + 32'(k * 8), 5'd1, 5'd5, 8'hD8);
      @(negedge clk) drive_simple(32'h304 + 32'(k * 8), 5'd5, 5'd6, 8'h80);
      #1 chk($sformatf("sat%0d stall", k), stall4, 1);
      @(posedge clk) #1;
      if (k == 14) begin
        chk("sat reach15 c4", stallCount4, 4'd15);
        chk("sat reach15 c32", stallCount, 15);
      end
    end
    chk("sat final c4", stallCount4, 4'd15);
    chk("sat final c32", stallCount, 20);
    chk("sat final bubble", exValid4, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
